// File: rtl/dial_combo_lock.sv
// Multi-round dial combination lock: the player turns the dial to a random
// target and presses the confirm key, NUM_ROUNDS times in a row, each within
// a per-round time limit. Wrong presses and timeouts are fails; MAX_FAILS
// fails start a timed lockout.
module dial_combo_lock #(
  parameter int POS_BITS       = 3,
  parameter int ADC_BITS       = 12,
  parameter int NUM_ROUNDS     = 3,
  parameter int TIME_LIMIT_SEC = 3,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_SEC    = 5,
  parameter int ANGLE_STEP     = 25
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [ADC_BITS-1:0]          adc_dial_val,
  input  logic                         btn_click,
  output logic [4*(2**POS_BITS)-1:0]   target_seg_data,
  output logic [(2**POS_BITS)-1:0]     cursor_led,
  output logic [7:0]                   servo_angle,
  output logic [3:0]                   round_idx,
  output logic [3:0]                   sec_left,
  output logic [3:0]                   fail_cnt,
  output logic                         clear,
  output logic                         fail,
  output logic                         locked
);

  localparam int NUM_POS = 2**POS_BITS;
  localparam int PW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_PLAY, S_LOCKOUT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic                btn_q, btn_d;
  logic [POS_BITS-1:0] target_pos_q, target_pos_d;
  logic [POS_BITS-1:0] prev_target_q, prev_target_d;
  logic [3:0]          round_q, round_d;
  logic [3:0]          fail_cnt_q, fail_cnt_d;
  logic [3:0]          sec_left_q, sec_left_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                clear_q, clear_d;
  logic                fail_q, fail_d;

  logic [POS_BITS-1:0] cur_pos;
  logic [POS_BITS-1:0] arm_pick;
  logic [15:0]         angle_full;
  logic                press, presc_wrap, time_up, fail_evt;

  assign cur_pos    = adc_dial_val[ADC_BITS-1 -: POS_BITS];
  assign press      = btn_click & ~btn_q;
  assign presc_wrap = (presc_q == PRESC_MAX);
  assign time_up    = presc_wrap && (sec_left_q == 4'd1);
  assign angle_full = 16'(cur_pos) * 16'(ANGLE_STEP);

  assign servo_angle = angle_full[7:0];
  assign round_idx   = round_q;
  assign sec_left    = sec_left_q;
  assign fail_cnt    = fail_cnt_q;
  assign clear       = clear_q;
  assign fail        = fail_q;
  assign locked      = (state_q == S_LOCKOUT);

  // State register; everything resets synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 16'hACE1;
      btn_q         <= 1'b0;
      target_pos_q  <= '0;
      prev_target_q <= '0;
      round_q       <= '0;
      fail_cnt_q    <= '0;
      sec_left_q    <= '0;
      presc_q       <= '0;
      clear_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      btn_q         <= btn_d;
      target_pos_q  <= target_pos_d;
      prev_target_q <= prev_target_d;
      round_q       <= round_d;
      fail_cnt_q    <= fail_cnt_d;
      sec_left_q    <= sec_left_d;
      presc_q       <= presc_d;
      clear_q       <= clear_d;
      fail_q        <= fail_d;
    end
  end

  // Next-state logic: round/lockout sequencing, seconds timer, fail handling.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    btn_d         = btn_click;
    target_pos_d  = target_pos_q;
    prev_target_d = prev_target_q;
    round_d       = round_q;
    fail_cnt_d    = fail_cnt_q;
    sec_left_d    = sec_left_q;
    presc_d       = presc_q;
    clear_d       = 1'b0;
    fail_d        = 1'b0;
    fail_evt      = 1'b0;
    // Never repeat the previous target, so every round needs a real turn.
    arm_pick      = lfsr_q[POS_BITS-1:0];
    if (arm_pick == prev_target_q) arm_pick = arm_pick + 1'b1;

    if (!enable) begin
      state_d    = S_IDLE;
      round_d    = '0;
      fail_cnt_d = '0;
      sec_left_d = '0;
      presc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          target_pos_d  = arm_pick;
          prev_target_d = arm_pick;
          sec_left_d    = 4'(TIME_LIMIT_SEC);
          presc_d       = '0;
          state_d       = S_PLAY;
        end
        S_PLAY: begin
          // Timeout beats a press landing in the same cycle.
          if (time_up) begin
            fail_evt = 1'b1;
          end else if (press && (cur_pos == target_pos_q)) begin
            round_d = round_q + 4'd1;
            if (round_d == 4'(NUM_ROUNDS)) begin
              clear_d = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_ARM;
            end
          end else if (press) begin
            fail_evt = 1'b1;
          end else begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) sec_left_d = sec_left_q - 4'd1;
          end
        end
        S_LOCKOUT: begin
          if (time_up) begin
            fail_cnt_d = '0;
            state_d    = S_ARM;
          end else begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) sec_left_d = sec_left_q - 4'd1;
          end
        end
        default: ;
      endcase

      if (fail_evt) begin
        fail_d     = 1'b1;
        round_d    = '0;
        fail_cnt_d = fail_cnt_q + 4'd1;
        if (fail_cnt_d == 4'(MAX_FAILS)) begin
          state_d    = S_LOCKOUT;
          sec_left_d = 4'(LOCKOUT_SEC);
          presc_d    = '0;
        end else begin
          state_d = S_ARM;
        end
      end
    end
  end

  // Digit display: target marked as 0 among B's while playing, E in lockout.
  always_comb begin
    target_seg_data = '0;
    for (int k = 0; k < NUM_POS; k++) begin
      case (state_q)
        S_ARM, S_PLAY: target_seg_data[4*k +: 4] =
                         (k == int'(target_pos_q)) ? 4'h0 : 4'hB;
        S_LOCKOUT:     target_seg_data[4*k +: 4] = 4'hE;
        default:       target_seg_data[4*k +: 4] = 4'h0;
      endcase
    end
  end

  // One-hot cursor follows the dial directly.
  always_comb begin
    cursor_led          = '0;
    cursor_led[cur_pos] = 1'b1;
  end

endmodule

// File: tb/tb_dial_combo_lock.sv
// Randomised bench for dial_combo_lock. A behavioural model (cycle counts
// per round instead of prescaler/second pairs) predicts clear/fail pulses
// into a queue; a negedge monitor pops them when the DUT pulses and also
// compares the visible counters, display, cursor and servo each cycle.
module tb_dial_combo_lock;
  localparam int PB = 3, AB = 12, NR = 3, TL = 2, CF = 10, MF = 2, LS = 1, AS = 25;
  localparam int NP = 1 << PB;
  localparam int RCYC = TL * CF, LCYC = LS * CF;
  localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_LOCK = 3, M_DONE = 4;

  logic clk = 1'b0;
  logic rst, enable, btn_click;
  logic [AB-1:0] adc;
  logic [4*NP-1:0] target_seg_data;
  logic [NP-1:0] cursor_led;
  logic [7:0] servo_angle;
  logic [3:0] round_idx, sec_left, fail_cnt;
  logic clear, fail, locked;

  dial_combo_lock #(.POS_BITS(PB), .ADC_BITS(AB), .NUM_ROUNDS(NR),
    .TIME_LIMIT_SEC(TL), .CLK_FREQ(CF), .MAX_FAILS(MF), .LOCKOUT_SEC(LS),
    .ANGLE_STEP(AS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_dial_val(adc),
    .btn_click(btn_click), .target_seg_data(target_seg_data),
    .cursor_led(cursor_led), .servo_angle(servo_angle), .round_idx(round_idx),
    .sec_left(sec_left), .fail_cnt(fail_cnt), .clear(clear), .fail(fail),
    .locked(locked));

  always #5 clk = ~clk;

  typedef struct { int kind; int cyc; } ev_t;  // kind 0 = clear, 1 = fail
  ev_t evq[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  bit mon_en = 0;

  // Reference model state
  int m_st, m_tgt, m_prev, m_round, m_fails, m_el;
  logic [15:0] m_lfsr;
  logic m_btn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: evaluates the rules once per clock on pre-edge values.
  always @(posedge clk) begin : model
    int pos, t;
    bit pr, go_fail;
    cyc++;
    if (rst) begin
      m_st = M_IDLE; m_lfsr = 16'hACE1; m_btn = 0; m_tgt = 0; m_prev = 0;
      m_round = 0; m_fails = 0; m_el = 0;
    end else begin
      pr = btn_click && !m_btn;
      pos = int'(adc) >> (AB - PB);
      go_fail = 0;
      if (!enable) begin
        m_st = M_IDLE; m_round = 0; m_fails = 0; m_el = 0;
      end else begin
        case (m_st)
          M_IDLE: m_st = M_ARM;
          M_ARM: begin
            t = int'(m_lfsr) % NP;
            if (t == m_prev) t = (t + 1) % NP;
            m_tgt = t; m_prev = t; m_el = 0; m_st = M_PLAY;
          end
          M_PLAY: begin
            if (m_el == RCYC - 1) go_fail = 1;
            else if (pr && pos == m_tgt) begin
              m_round++;
              if (m_round == NR) begin evq.push_back('{0, cyc}); m_st = M_DONE; end
              else m_st = M_ARM;
            end else if (pr) go_fail = 1;
            else m_el++;
          end
          M_LOCK: begin
            if (m_el == LCYC - 1) begin m_fails = 0; m_st = M_ARM; end
            else m_el++;
          end
          default: ;
        endcase
        if (go_fail) begin
          evq.push_back('{1, cyc});
          m_round = 0; m_fails++;
          if (m_fails == MF) begin m_st = M_LOCK; m_el = 0; end
          else m_st = M_ARM;
        end
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_btn = btn_click;
    end
  end

  function automatic logic [4*NP-1:0] exp_seg();
    logic [4*NP-1:0] s;
    s = '0;
    for (int k = 0; k < NP; k++) begin
      if (m_st == M_ARM || m_st == M_PLAY) s[4*k +: 4] = (k == m_tgt) ? 4'h0 : 4'hB;
      else if (m_st == M_LOCK) s[4*k +: 4] = 4'hE;
    end
    return s;
  endfunction

  // Monitor: pulse scoreboard plus per-cycle observable state.
  always @(negedge clk) begin : monitor
    ev_t e;
    int pos;
    if (mon_en) begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        chk(e.kind == 0 ? "missing_clear_pulse" : "missing_fail_pulse", 0, 1);
      end
      if (clear || fail) begin
        if (evq.size() == 0) chk("unexpected_pulse", {clear, fail}, 0);
        else begin
          e = evq.pop_front();
          chk("pulse_kind", {clear, fail}, (e.kind == 0) ? 2'b10 : 2'b01);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
      pos = int'(adc) >> (AB - PB);
      chk("round_idx", round_idx, m_round);
      chk("fail_cnt", fail_cnt, m_fails);
      chk("locked", locked, m_st == M_LOCK);
      chk("display", target_seg_data, exp_seg());
      chk("cursor_led", cursor_led, 64'd1 << pos);
      chk("servo_angle", servo_angle, (pos * AS) % 256);
      if (m_st == M_PLAY) chk("sec_left_play", sec_left, TL - m_el / CF);
      if (m_st == M_LOCK) chk("sec_left_lock", sec_left, LS - m_el / CF);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_st(input int s, input int bound, input string name);
    int i;
    i = 0;
    while (m_st != s && i < bound) begin tick(1); i++; end
    chk(name, m_st, s);
  endtask

  task automatic press_at(input int p);
    adc = AB'(((p % NP) << (AB - PB)) | $urandom_range(0, (1 << (AB - PB)) - 1));
    btn_click = 1'b1;
    tick(1);
    btn_click = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0; tick(2); enable = 1'b1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    logic [4*NP-1:0] prev_seg;
    int i;
    rst = 1'b1; enable = 1'b0; btn_click = 1'b0; adc = '0;
    tick(2);
    chk("rst_round", round_idx, 0); chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_sec_left", sec_left, 0); chk("rst_pulses", {clear, fail, locked}, 0);
    chk("rst_display", target_seg_data, 0); chk("rst_servo", servo_angle, 0);
    mon_en = 1;
    rst = 1'b0;

    // Three correct rounds -> clear, DONE
    enable = 1'b1;
    for (int r = 0; r < NR; r++) begin
      wait_st(M_PLAY, 10, "t1_reach_play");
      tick($urandom_range(0, 5));
      press_at(m_tgt);
    end
    tick(3);
    chk("t1_round_done", round_idx, NR);
    chk("t1_display_zero", target_seg_data, 0);

    // Timeout with no press
    restart();
    wait_st(M_PLAY, 10, "t2_reach_play");
    prev_seg = target_seg_data;
    tick(RCYC + 1);
    chk("t2_fail_cnt", fail_cnt, 1);
    wait_st(M_PLAY, 10, "t2_replay");
    chk("t2_target_changed", target_seg_data != prev_seg, 1);

    // Two wrong presses -> lockout; presses ignored inside it
    restart();
    for (int k = 0; k < MF; k++) begin
      wait_st(M_PLAY, 10, "t3_reach_play");
      press_at(m_tgt + 1 + $urandom_range(0, NP - 2));
    end
    tick(1);
    chk("t3_locked", locked, 1);
    for (int k = 0; k < 3; k++) press_at($urandom_range(0, NP - 1));
    wait_st(M_ARM, LCYC + 2, "t3_lock_exit");
    chk("t3_fail_cnt_cleared", fail_cnt, 0);

    // Correct press in the timeout cycle -> fail only
    wait_st(M_PLAY, 10, "t4_reach_play");
    i = 0;
    while (!(m_st == M_PLAY && m_el == RCYC - 1) && i < 40) begin tick(1); i++; end
    chk("t4_at_deadline", m_el, RCYC - 1);
    press_at(m_tgt);
    chk("t4_no_round", round_idx, 0);
    chk("t4_fail_cnt", fail_cnt, 1);

    // Held key counts once
    restart();
    wait_st(M_PLAY, 10, "t5_reach_play");
    adc = AB'(m_tgt << (AB - PB));
    btn_click = 1'b1;
    tick(3);
    chk("t5_round_once", round_idx, 1);
    tick(27);
    btn_click = 1'b0;

    // Dial sweep in IDLE
    enable = 1'b0;
    for (int a = 0; a < (1 << AB); a += 4) begin adc = AB'(a); tick(1); end
    adc = AB'(7 << (AB - PB));
    tick(1);
    chk("servo_pos7", servo_angle, 175);
    chk("cursor_pos7", cursor_led, 8'h80);

    // Enable drop at round 2
    enable = 1'b1;
    for (int r = 0; r < 2; r++) begin
      wait_st(M_PLAY, 10, "t6_reach_play");
      press_at(m_tgt);
    end
    wait_st(M_PLAY, 10, "t6_play_r2");
    tick(3);
    chk("t6_round2", round_idx, 2);
    enable = 1'b0;
    tick(1);
    chk("t6_drop_counters", {round_idx, fail_cnt, sec_left}, 0);
    chk("t6_drop_flags", {clear, fail, locked}, 0);

    // Reset mid-lockout
    enable = 1'b1;
    for (int k = 0; k < MF; k++) begin
      wait_st(M_PLAY, 10, "t7_reach_play");
      press_at(m_tgt + 1);
    end
    tick(3);
    chk("t7_locked", locked, 1);
    rst = 1'b1;
    tick(1);
    chk("t7_rst_counters", {round_idx, fail_cnt, sec_left}, 0);
    chk("t7_rst_flags", {clear, fail, locked}, 0);
    rst = 1'b0;

    // Random play
    for (int n = 0; n < 500; n++) begin
      enable = ($urandom_range(0, 60) != 0);
      btn_click = ($urandom_range(0, 3) == 0);
      adc = $urandom_range(0, 1) ? AB'(m_tgt << (AB - PB)) : AB'($urandom);
      tick(1);
    end
    btn_click = 1'b0;
    tick(3);
    chk("queue_drained", evq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
